// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - convolution read scheduler: kernel load, line streaming, window tracking
// Define CONV_SCHED_PERF_EN to add the perf_stall_cycles output and its counter.
module conv_sched #(
  parameter int SRAM_ADDRESS_WIDTH = 12,
  parameter int ADDR_STEP          = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [SRAM_ADDRESS_WIDTH-1:0] cfg_kernel_addr,
  input  logic [SRAM_ADDRESS_WIDTH-1:0] cfg_image_addr,
  input  logic [9:0]                    cfg_num_lines,
  input  logic                          results_stall,
  output logic [SRAM_ADDRESS_WIDTH-1:0] read_address,
  output logic                          read_enable,
  input  logic                          read_valid,
  output logic                          kernel_we,
  output logic                          kernel_row,
  output logic                          line_shift,
  output logic                          window_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          error
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [15:0]                   perf_stall_cycles
`endif
);

  localparam int AW = SRAM_ADDRESS_WIDTH;
  localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, KLOAD, STREAM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] kern_ptr, img_ptr;
  logic [9:0]    num_lines, issue_cnt, rx_cnt;
  logic [1:0]    k_issue;
  logic          k_rx;
  logic          pending, win_q, done_q, err_q;
  logic          start_ok, start_bad, stray, resp;
  logic [9:0]    last_idx;

  assign start_ok  = (state == IDLE) && start && !abort && (cfg_num_lines >= 10'd4);
  assign start_bad = (state == IDLE) && start && !abort && (cfg_num_lines < 10'd4);
  // SRAM latency is exactly one cycle, so a response is legal only after last cycle's issue
  assign stray     = read_valid && !pending;
  assign resp      = read_valid && pending && !abort;
  assign last_idx  = num_lines - 10'd1;

  assign kernel_we    = resp && (state == KLOAD);
  assign kernel_row   = k_rx;
  assign line_shift   = resp && ((state == STREAM) || (state == DRAIN));
  assign window_valid = win_q;
  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign error        = err_q;

  always_comb begin
    read_enable  = 1'b0;
    read_address = '0;
    case (state)
      KLOAD: begin
        read_enable  = (k_issue < 2'd2);
        read_address = kern_ptr;
      end
      STREAM: begin
        read_enable  = (issue_cnt != num_lines);
        read_address = img_ptr;
      end
      default: ;
    endcase
    if (results_stall || abort) read_enable = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = KLOAD;
      KLOAD:   if (kernel_we && k_rx) state_nxt = STREAM;
      STREAM:  if (read_enable && (issue_cnt == last_idx)) state_nxt = DRAIN;
      DRAIN:   if (line_shift && (rx_cnt == last_idx)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      kern_ptr  <= '0;
      img_ptr   <= '0;
      num_lines <= '0;
      issue_cnt <= '0;
      rx_cnt    <= '0;
      k_issue   <= '0;
      k_rx      <= 1'b0;
      pending   <= 1'b0;
      win_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= read_enable;
      win_q   <= line_shift && (rx_cnt >= 10'd3);
      done_q  <= line_shift && (state == DRAIN) && (rx_cnt == last_idx) && !abort;
      if (start_ok) begin
        kern_ptr  <= cfg_kernel_addr;
        img_ptr   <= cfg_image_addr;
        num_lines <= cfg_num_lines;
        issue_cnt <= '0;
        rx_cnt    <= '0;
        k_issue   <= '0;
        k_rx      <= 1'b0;
      end else begin
        if (read_enable && (state == KLOAD)) begin
          kern_ptr <= kern_ptr + STEP;
          k_issue  <= k_issue + 2'd1;
        end
        if (read_enable && (state == STREAM)) begin
          img_ptr   <= img_ptr + STEP;
          issue_cnt <= issue_cnt + 10'd1;
        end
        if (kernel_we)  k_rx   <= 1'b1;
        if (line_shift) rx_cnt <= rx_cnt + 10'd1;
      end
      if (stray || start_bad) err_q <= 1'b1;
      else if (start_ok)      err_q <= 1'b0;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [15:0] perf_q;
  assign perf_stall_cycles = perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (((state == KLOAD) || (state == STREAM)) && results_stall && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter SRAM_ADDRESS_WIDTH, default 12, SHALL set the byte-address width of all address ports.
REQ-002 Parameter ADDR_STEP, default 8, SHALL set the byte increment between consecutive 64-bit SRAM words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-006 abort  input  1  terminates any job; honoured in every state.
REQ-007 cfg_kernel_addr  input  SRAM_ADDRESS_WIDTH  base of the 2 kernel words; sampled on accepted start.
REQ-008 cfg_image_addr  input  SRAM_ADDRESS_WIDTH  base of the image lines; sampled on accepted start.
REQ-009 cfg_num_lines  input  10  number of image words to stream; sampled on accepted start.
REQ-010 results_stall  input  1  downstream write port busy; issuing new reads is paused.
REQ-011 read_address  output  SRAM_ADDRESS_WIDTH  SRAM read address.
REQ-012 read_enable  output  1  SRAM read request; response arrives exactly 1 cycle later.
REQ-013 read_valid  input  1  SRAM read response strobe.
REQ-014 kernel_we  output  1  capture read data into kernel storage this cycle.
REQ-015 kernel_row  output  1  kernel word index (0: rows 0-1, 1: rows 2-3) qualified by kernel_we.
REQ-016 line_shift  output  1  shift line buffers and insert read data this cycle.
REQ-017 window_valid  output  1  line buffers hold 4 valid lines; convolution output is writable.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on normal job completion.
REQ-020 error  output  1  sticky protocol-error flag.

Function
REQ-021 States SHALL be IDLE, KLOAD, STREAM, DRAIN; reset state IDLE.
REQ-022 IDLE: start=1, abort=0, cfg_num_lines>=4 SHALL latch cfg_* and go to KLOAD next cycle; cfg_num_lines<4 SHALL stay IDLE and set error.
REQ-023 KLOAD SHALL issue reads at kernel_addr then kernel_addr+ADDR_STEP, one per cycle when results_stall=0.
REQ-024 kernel_we SHALL equal read_valid during KLOAD responses; kernel_row=0 for the first response, 1 for the second.
REQ-025 KLOAD SHALL go to STREAM the cycle after the second kernel response; first image read issues in that STREAM cycle.
REQ-026 STREAM SHALL issue cfg_num_lines reads from image_addr, stepping ADDR_STEP, one per cycle when results_stall=0; go to DRAIN after the last issue.
REQ-027 line_shift SHALL equal read_valid for every image response, including responses in DRAIN.
REQ-028 window_valid SHALL be a registered pulse: high the cycle after each line_shift that brings the received-line count to >=4.
REQ-029 results_stall SHALL force read_enable=0 combinationally; an already issued read still completes and is processed.
REQ-030 DRAIN SHALL wait for the last response; done SHALL pulse in the cycle window_valid pulses for the last line, with return to IDLE the same edge.
REQ-031 Address arithmetic SHALL wrap modulo 2^SRAM_ADDRESS_WIDTH.
REQ-032 abort SHALL force IDLE next cycle, with read_enable=0 in the abort cycle and a suppressed in-flight response (no kernel_we/line_shift); done SHALL not pulse.
REQ-033 start and abort in the same cycle: abort SHALL win.
REQ-034 read_valid with no read outstanding SHALL be ignored and set error; error SHALL clear only on an accepted start.

Reset
REQ-035 reset_n low SHALL asynchronously force IDLE and zero all counters, latched cfg values and outputs (read_address=0, error=0).
REQ-036 Reset mid-job SHALL discard the job; no done and no strobes after release.

Configuration
REQ-037 With CONV_SCHED_PERF_EN defined, output perf_stall_cycles (16 bits) SHALL count cycles in KLOAD/STREAM with results_stall=1, saturating at 0xFFFF and cleared on accepted start.
REQ-038 Without CONV_SCHED_PERF_EN, the perf_stall_cycles port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-039 start, kernel=0x000, image=0x010, lines=4, no stall -> reads 0x000,0x008,0x010..0x028; kernel_row 0,1; 4 line_shifts; 1 window_valid; done 1 cycle later.
REQ-040 lines=130, results_stall high 5 cycles mid-STREAM -> no read_enable during stall; 130 line_shifts; 127 window_valid pulses; done once; perf_stall_cycles=5 (macro on).
REQ-041 image=0xFF8, lines=4 -> addresses 0xFF8,0x000,0x008,0x010.
REQ-042 abort 1 cycle after the 3rd image read -> that response yields no line_shift; busy=0 next cycle; done never asserted.
REQ-043 start with lines=3 -> stays IDLE, error=1; next start with lines=4 clears error.
REQ-044 read_valid pulse in IDLE -> no strobes, error=1; start+abort same cycle -> remains IDLE.
